// File: rtl/lisnoc_def_pkg.sv
// Shared lisnoc flit definitions: flit type codes, destination field layout and sink FSM states.
package lisnoc_def;

   localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
   localparam logic [1:0] FLIT_TYPE_HEAD    = 2'b01;
   localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
   localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

   // destination occupies the top FLIT_DEST_WIDTH bits of the flit data
   localparam int FLIT_DEST_WIDTH = 5;

   typedef enum logic [1:0] {
      SINK_IDLE = 2'b00,
      SINK_RECV = 2'b01,
      SINK_DROP = 2'b10
   } sink_state_t;

   // LAST and SINGLE both close a packet
   function automatic logic flit_is_tail(input logic [1:0] ftype);
      return ftype[1];
   endfunction

endpackage

// File: rtl/lisnoc_packet_sink_buf.sv
// Packet buffer: RAM plus write/commit/read pointers; uncommitted words can be rewound.
module lisnoc_packet_sink_buf #(
   parameter int DW    = 32,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_last,
   input  logic          commit,
   input  logic          rewind,
   input  logic          pop,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic          full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DW:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] commit_ptr;
   logic [PW-1:0] rd_ptr;

   // pointer updates; rewind discards everything written since the last commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
      end else begin
         if (rewind)
            wr_ptr <= commit_ptr;
         else if (wr_en)
            wr_ptr <= wr_ptr + PW'(1);
         if (wr_en && commit)
            commit_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // storage array, not reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
   end

   assign {rd_last, rd_data} = mem[rd_ptr[AW-1:0]];
   assign full = (wr_ptr - rd_ptr) == PW'(DEPTH);

endmodule

// File: rtl/lisnoc_packet_sink.sv
// Store-and-forward ejection endpoint: reassembles packets from one VC and streams whole packets out.
// Optional destination check enabled by defining LISNOC_SINK_DEST_CHECK_EN.
module lisnoc_packet_sink
   import lisnoc_def::*;
#(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int VCHANNELS       = 1,
   parameter int VC_SEL          = 0,
   parameter int DEPTH           = 16,
   parameter int ID              = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FLIT_DATA_WIDTH+1:0] in_flit,
   input  logic [VCHANNELS-1:0]       in_valid,
   output logic [VCHANNELS-1:0]       in_ready,
   output logic [FLIT_DATA_WIDTH-1:0] out_data,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_framing,
   output logic                       err_overflow,
   output logic                       err_dest
);

   localparam int FW = FLIT_DATA_WIDTH;
   localparam int PW = $clog2(DEPTH) + 1;

   sink_state_t   state, state_nx;
   logic [PW-1:0] pkt_cnt;
   logic [1:0]    ftype;
   logic          acc, dest_ok, full, pop, dec;
   logic          wr_en, wr_last, commit, rewind, cnt_inc;
   logic          e_fr, e_ov, e_de;
   logic [FW-1:0] rd_data;
   logic          rd_last;

   assign ftype = in_flit[FW+1 -: 2];

`ifdef LISNOC_SINK_DEST_CHECK_EN
   logic [FLIT_DEST_WIDTH-1:0] dest;
   assign dest    = in_flit[FW-1 -: FLIT_DEST_WIDTH];
   assign dest_ok = (dest == FLIT_DEST_WIDTH'(ID));
`else
   assign dest_ok = 1'b1;
`endif

   always_comb begin
      in_ready         = '1;
      in_ready[VC_SEL] = (state == SINK_DROP) | ~full;
   end

   assign acc = in_valid[VC_SEL] & in_ready[VC_SEL];

   // next-state and buffer control decode
   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_last  = 1'b0;
      commit   = 1'b0;
      rewind   = 1'b0;
      cnt_inc  = 1'b0;
      e_fr     = 1'b0;
      e_ov     = 1'b0;
      e_de     = 1'b0;
      unique case (state)
         SINK_IDLE: begin
            if (acc) begin
               unique case (ftype)
                  FLIT_TYPE_HEAD: begin
                     if (dest_ok) begin
                        wr_en    = 1'b1;
                        state_nx = SINK_RECV;
                     end else begin
                        e_de     = 1'b1;
                        state_nx = SINK_DROP;
                     end
                  end
                  FLIT_TYPE_SINGLE: begin
                     if (dest_ok) begin
                        wr_en   = 1'b1;
                        wr_last = 1'b1;
                        commit  = 1'b1;
                        cnt_inc = 1'b1;
                     end else begin
                        e_de    = 1'b1;
                     end
                  end
                  FLIT_TYPE_PAYLOAD: begin
                     e_fr     = 1'b1;
                     state_nx = SINK_DROP;
                  end
                  default: e_fr = 1'b1;
               endcase
            end else begin
               state_nx = SINK_IDLE;
            end
         end
         SINK_RECV: begin
            // nothing committed can ever free space, so the packet cannot fit
            if (full && (pkt_cnt == '0) && in_valid[VC_SEL]) begin
               e_ov     = 1'b1;
               rewind   = 1'b1;
               state_nx = SINK_DROP;
            end else if (acc) begin
               unique case (ftype)
                  FLIT_TYPE_PAYLOAD: wr_en = 1'b1;
                  FLIT_TYPE_LAST: begin
                     wr_en    = 1'b1;
                     wr_last  = 1'b1;
                     commit   = 1'b1;
                     cnt_inc  = 1'b1;
                     state_nx = SINK_IDLE;
                  end
                  FLIT_TYPE_HEAD: begin
                     e_fr     = 1'b1;
                     rewind   = 1'b1;
                     state_nx = SINK_DROP;
                  end
                  default: begin
                     e_fr     = 1'b1;
                     rewind   = 1'b1;
                     state_nx = SINK_IDLE;
                  end
               endcase
            end else begin
               state_nx = SINK_RECV;
            end
         end
         SINK_DROP: begin
            if (acc && flit_is_tail(ftype))
               state_nx = SINK_IDLE;
            else
               state_nx = SINK_DROP;
         end
         default: state_nx = SINK_IDLE;
      endcase
   end

   assign pop = out_valid & out_ready;
   assign dec = pop & rd_last;

   // state, packet count and registered error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SINK_IDLE;
         pkt_cnt      <= '0;
         err_framing  <= 1'b0;
         err_overflow <= 1'b0;
         err_dest     <= 1'b0;
      end else begin
         state        <= state_nx;
         err_framing  <= e_fr;
         err_overflow <= e_ov;
         err_dest     <= e_de;
         unique case ({cnt_inc, dec})
            2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   lisnoc_packet_sink_buf #(
      .DW    (FW),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (in_flit[FW-1:0]),
      .wr_last (wr_last),
      .commit  (commit),
      .rewind  (rewind),
      .pop     (pop),
      .rd_data (rd_data),
      .rd_last (rd_last),
      .full    (full)
   );

   // word visible only while a whole packet is committed
   assign out_valid = (pkt_cnt != '0);
   assign out_data  = out_valid ? rd_data : '0;
   assign out_last  = out_valid & rd_last;

endmodule

// File: tb/tb_lisnoc_packet_sink.sv
// Directed self-checking bench for lisnoc_packet_sink (DEPTH=8, ID=2).
module tb_lisnoc_packet_sink;

   localparam logic [1:0] PL = 2'b00;
   localparam logic [1:0] HD = 2'b01;
   localparam logic [1:0] LS = 2'b10;
   localparam logic [1:0] SG = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [33:0] in_flit = '0;
   logic [0:0]  in_valid = 1'b0;
   logic [0:0]  in_ready;
   logic [31:0] out_data;
   logic        out_last, out_valid;
   logic        out_ready = 1'b0;
   logic        err_framing, err_overflow, err_dest;

   int n_cmp = 0;
   int n_err = 0;
   int fr_cnt = 0, ov_cnt = 0, de_cnt = 0, acc_cnt = 0;
   logic [32:0] got_q[$];
   logic [32:0] exp_q[$];

   lisnoc_packet_sink #(
      .FLIT_DATA_WIDTH (32),
      .VCHANNELS       (1),
      .VC_SEL          (0),
      .DEPTH           (8),
      .ID              (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_flit      (in_flit),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .err_framing  (err_framing),
      .err_overflow (err_overflow),
      .err_dest     (err_dest)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // head/single data carrying this tile's dest when the dest check is built in
   function automatic logic [31:0] hd(input logic [31:0] d);
`ifdef LISNOC_SINK_DEST_CHECK_EN
      return {5'd2, d[26:0]};
`else
      return d;
`endif
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // called at posedge+1; returns at posedge+1 after the handshake edge
   task automatic send_flit(input logic [1:0] t, input logic [31:0] d);
      int n = 0;
      in_flit  = {t, d};
      in_valid = 1'b1;
      while (!in_ready[0] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check_val("ready_timeout", in_ready, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic cmp_beats(input string tag);
      check_val({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_val(tag, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   // negedge monitor: beats, accepted flits, error pulses, output hold while stalled
   initial begin
      logic        stall_prev = 1'b0;
      logic [32:0] held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) check_val("hold_stable", {out_last, out_data}, held);
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (in_valid[0] && in_ready[0]) acc_cnt++;
            if (err_framing)  fr_cnt++;
            if (err_overflow) ov_cnt++;
            if (err_dest)     de_cnt++;
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_data};
         end
      end
   end

   initial begin
      int a0;
      idle(3);
      rst = 1'b0;
      #1;
      check_val("rst_out_valid", out_valid, 64'd0);
      check_val("rst_out_data", out_data, 64'd0);
      check_val("rst_out_last", out_last, 64'd0);
      check_val("rst_in_ready", in_ready, 64'd1);
      check_val("rst_errs", {err_framing, err_overflow, err_dest}, 64'd0);

      // 1: SINGLE, visible the cycle after acceptance
      out_ready = 1'b1;
      send_flit(SG, hd(32'h0800_1234));
      check_val("t1_valid", out_valid, 64'd1);
      check_val("t1_data", out_data, hd(32'h0800_1234));
      check_val("t1_last", out_last, 64'd1);
      idle(4);
      exp_q.push_back({1'b1, hd(32'h0800_1234)});
      cmp_beats("t1_beats");

      // 2: four-flit packet held until LAST, then drained
      out_ready = 1'b0;
      send_flit(HD, hd(32'h0000_00A0));
      check_val("t2_nv_head", out_valid, 64'd0);
      send_flit(PL, 32'h1);
      send_flit(PL, 32'h2);
      check_val("t2_nv_pay", out_valid, 64'd0);
      send_flit(LS, 32'h3);
      check_val("t2_valid", out_valid, 64'd1);
      idle(2);
      out_ready = 1'b1;
      idle(8);
      exp_q.push_back({1'b0, hd(32'h0000_00A0)});
      exp_q.push_back({1'b0, 32'h1});
      exp_q.push_back({1'b0, 32'h2});
      exp_q.push_back({1'b1, 32'h3});
      cmp_beats("t2_beats");

      // 3: framing error in IDLE, then normal SINGLE
      send_flit(PL, 32'h7);
      send_flit(LS, 32'h8);
      idle(3);
      check_val("t3_framing", fr_cnt, 64'd1);
      cmp_beats("t3_none");
      send_flit(SG, hd(32'h77));
      idle(4);
      exp_q.push_back({1'b1, hd(32'h77)});
      cmp_beats("t3_beats");

      // 4: 10-flit packet into empty 8-deep buffer
      a0 = acc_cnt;
      send_flit(HD, hd(32'h100));
      for (int i = 1; i < 9; i++) send_flit(PL, 32'h100 + i);
      send_flit(LS, 32'h109);
      idle(3);
      check_val("t4_overflow", ov_cnt, 64'd1);
      check_val("t4_framing", fr_cnt, 64'd1);
      check_val("t4_accepted", acc_cnt - a0, 64'd10);
      check_val("t4_empty", out_valid, 64'd0);
      cmp_beats("t4_none");
      send_flit(SG, hd(32'h55));
      idle(4);
      exp_q.push_back({1'b1, hd(32'h55)});
      cmp_beats("t4_beats");

      // 5: backpressure while a committed packet occupies the buffer
      out_ready = 1'b0;
      send_flit(HD, hd(32'h10));
      for (int i = 1; i < 5; i++) send_flit(PL, 32'h10 + i);
      send_flit(LS, 32'h15);
      a0 = acc_cnt;
      fork
         begin
            send_flit(HD, hd(32'h20));
            send_flit(PL, 32'h21);
            send_flit(PL, 32'h22);
            send_flit(LS, 32'h23);
         end
         begin
            idle(12);
            check_val("t5_accepted", acc_cnt - a0, 64'd2);
            check_val("t5_ready_low", in_ready, 64'd0);
            check_val("t5_valid", out_valid, 64'd1);
            out_ready = 1'b1;
         end
      join
      idle(12);
      exp_q.push_back({1'b0, hd(32'h10)});
      for (int i = 1; i < 5; i++) exp_q.push_back({1'b0, 32'h10 + i});
      exp_q.push_back({1'b1, 32'h15});
      exp_q.push_back({1'b0, hd(32'h20)});
      exp_q.push_back({1'b0, 32'h21});
      exp_q.push_back({1'b0, 32'h22});
      exp_q.push_back({1'b1, 32'h23});
      cmp_beats("t5_beats");

      // 6: head addressed to tile 3
      send_flit(HD, 32'h1800_0000);
      send_flit(LS, 32'h9);
      idle(4);
`ifdef LISNOC_SINK_DEST_CHECK_EN
      check_val("t6_dest", de_cnt, 64'd1);
`else
      check_val("t6_dest", de_cnt, 64'd0);
      exp_q.push_back({1'b0, 32'h1800_0000});
      exp_q.push_back({1'b1, 32'h9});
`endif
      cmp_beats("t6_beats");

      // reset mid-packet with a committed packet pending
      out_ready = 1'b0;
      send_flit(SG, hd(32'h31));
      send_flit(HD, hd(32'h0));
      send_flit(PL, 32'h32);
      check_val("rm_pre_valid", out_valid, 64'd1);
      rst = 1'b1;
      #1;
      check_val("rm_out_valid", out_valid, 64'd0);
      check_val("rm_out_data", out_data, 64'd0);
      check_val("rm_out_last", out_last, 64'd0);
      idle(2);
      rst = 1'b0;
      #1;
      check_val("rm_in_ready", in_ready, 64'd1);
      out_ready = 1'b1;
      send_flit(SG, hd(32'h42));
      idle(4);
      exp_q.push_back({1'b1, hd(32'h42)});
      cmp_beats("rm_beats");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
